// File: rtl/card_dealer_if.sv
// Bundle of game-FSM handshake, shuffled-deck RAM port and dealt-card results
// between the card dealer and its neighbours.
interface card_dealer_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 4
);
  localparam int unsigned LEFT_W = 6;
  localparam int unsigned PTS_W  = 4;

  logic              enable;
  logic              request;
  logic [DATA_W-1:0] memData;
  logic [ADDR_W-1:0] nextA;
  logic              memClock;
  logic              wren;
  logic              busy;
  logic              card_valid;
  logic [DATA_W-1:0] card;
  logic [PTS_W-1:0]  points;
  logic              bad_card;
  logic [LEFT_W-1:0] cards_left;
  logic              empty;

  // Game FSM / RAM side
  modport master (
    output enable, request, memData,
    input  nextA, memClock, wren, busy, card_valid, card, points, bad_card,
           cards_left, empty
  );

  // Dealer side
  modport slave (
    input  enable, request, memData,
    output nextA, memClock, wren, busy, card_valid, card, points, bad_card,
           cards_left, empty
  );
endinterface

// File: rtl/card_dealer.sv
// Sequential reader of the shuffled deck: fetches one card per request over the
// shared RAM port and reports its code, point value and the cards remaining.
module card_dealer #(
  parameter int unsigned DECK_SIZE = 52,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clock,
  input  logic          resetn,
  card_dealer_if.slave  bus
);
  localparam int unsigned LEFT_W = 6;
  localparam int unsigned PTS_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_FETCH, S_STROBE, S_CAPTURE, S_DONE, S_EMPTY
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEFT_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] card_q, card_d;
  logic [PTS_W-1:0]  points_q, points_d;
  logic              bad_q, bad_d;
  logic              mem_clock_q, busy_q, card_valid_q, empty_q;
  logic [PTS_W-1:0]  dec_points;
  logic              dec_bad;

  // Point value of the word currently on the RAM read bus
  always_comb begin
    dec_points = '0;
    dec_bad    = 1'b0;
    if (bus.memData >= DATA_W'(1) && bus.memData <= DATA_W'(10)) begin
      dec_points = PTS_W'(bus.memData);
    end else if (bus.memData >= DATA_W'(11) && bus.memData <= DATA_W'(13)) begin
      dec_points = PTS_W'(10);
    end else begin
      dec_bad = 1'b1;
    end
  end

  // Next-state and datapath updates; enable low aborts everything back to IDLE
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    left_d   = left_q;
    card_d   = card_q;
    points_d = points_q;
    bad_d    = bad_q;
    if (!bus.enable) begin
      state_d = S_IDLE;
      ptr_d   = ADDR_W'(BASE_ADDR);
      left_d  = LEFT_W'(DECK_SIZE);
    end else begin
      unique case (state_q)
        S_IDLE:   state_d = S_READY;
        S_READY: begin
          if (left_q == '0)     state_d = S_EMPTY;
          else if (bus.request) state_d = S_FETCH;
        end
        S_FETCH:  state_d = S_STROBE;
        S_STROBE: state_d = S_CAPTURE;
        S_CAPTURE: begin
          state_d  = S_DONE;
          card_d   = bus.memData;
          points_d = dec_points;
          bad_d    = dec_bad;
        end
        S_DONE: begin
          state_d = S_READY;
          ptr_d   = ptr_q + ADDR_W'(1);
          left_d  = left_q - LEFT_W'(1);
        end
        S_EMPTY:  state_d = S_EMPTY;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // State, datapath and state-decoded strobes, registered together
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      ptr_q        <= ADDR_W'(BASE_ADDR);
      left_q       <= LEFT_W'(DECK_SIZE);
      card_q       <= '0;
      points_q     <= '0;
      bad_q        <= 1'b0;
      mem_clock_q  <= 1'b0;
      busy_q       <= 1'b0;
      card_valid_q <= 1'b0;
      empty_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      left_q       <= left_d;
      card_q       <= card_d;
      points_q     <= points_d;
      bad_q        <= bad_d;
      mem_clock_q  <= (state_d == S_STROBE);
      busy_q       <= (state_d == S_FETCH) || (state_d == S_STROBE) ||
                      (state_d == S_CAPTURE) || (state_d == S_DONE);
      card_valid_q <= (state_d == S_DONE);
      empty_q      <= (state_d == S_EMPTY);
    end
  end

  assign bus.nextA      = ptr_q;
  assign bus.memClock   = mem_clock_q;
  assign bus.wren       = 1'b0;
  assign bus.busy       = busy_q;
  assign bus.card_valid = card_valid_q;
  assign bus.card       = card_q;
  assign bus.points     = points_q;
  assign bus.bad_card   = bad_q;
  assign bus.cards_left = left_q;
  assign bus.empty      = empty_q;
endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer with a small RAM model.
module tb_card_dealer;
  logic clock;
  logic resetn;

  card_dealer_if #(.ADDR_W(6), .DATA_W(4)) bus ();

  card_dealer #(
    .DECK_SIZE(52), .ADDR_W(6), .DATA_W(4), .BASE_ADDR(0)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: read data latched on the rising memClock strobe
  logic [3:0] ram [64];
  logic [3:0] rd_q;
  int         strobe_cnt;
  int         strobe_addr;
  int         strobe_wren;
  initial begin
    rd_q        = 4'd0;
    strobe_cnt  = 0;
    strobe_addr = -1;
    strobe_wren = 0;
  end
  always @(posedge bus.memClock) begin
    rd_q        <= ram[bus.nextA];
    strobe_cnt  = strobe_cnt + 1;
    strobe_addr = int'(bus.nextA);
    if (bus.wren !== 1'b0) strobe_wren = strobe_wren + 1;
  end
  assign bus.memData = rd_q;

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ticks until card_valid is seen; drop_req releases request after the first edge
  task automatic wait_valid(input bit drop_req, output int cyc);
    bit found;
    found = 1'b0;
    cyc   = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (drop_req && n == 1) bus.request = 1'b0;
      if (bus.card_valid === 1'b1) begin
        cyc   = n;
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL card_valid_timeout got none expected pulse within 20 cycles");
    end
  endtask

  typedef struct {
    logic [3:0] code;
    logic [3:0] exp_points;
    logic       exp_bad;
  } vec_t;

  vec_t vecs [6];
  int   cyc;
  int   s0;
  int   vseen;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{4'd0,  4'd0,  1'b1};
    vecs[1] = '{4'd15, 4'd0,  1'b1};
    vecs[2] = '{4'd11, 4'd10, 1'b0};
    vecs[3] = '{4'd13, 4'd10, 1'b0};
    vecs[4] = '{4'd14, 4'd0,  1'b1};
    vecs[5] = '{4'd5,  4'd5,  1'b0};

    for (int i = 0; i < 64; i++) ram[i] = 4'((i % 13) + 1);
    ram[0] = 4'd1;
    ram[1] = 4'd12;
    ram[2] = 4'd10;
    for (int i = 0; i < 6; i++) ram[3 + i] = vecs[i].code;

    resetn      = 1'b0;
    bus.enable  = 1'b0;
    bus.request = 1'b0;
    #12;
    chk("rst_cards_left", 32'(bus.cards_left), 32'd52);
    chk("rst_card", 32'(bus.card), 32'd0);
    chk("rst_points", 32'(bus.points), 32'd0);
    chk("rst_bad", 32'(bus.bad_card), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_memclock", 32'(bus.memClock), 32'd0);
    chk("rst_valid", 32'(bus.card_valid), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd0);
    chk("rst_nextA", 32'(bus.nextA), 32'd0);
    chk("rst_wren", 32'(bus.wren), 32'd0);

    resetn     = 1'b1;
    bus.enable = 1'b1;
    tick();
    tick();

    // Single card from address 0
    s0 = strobe_cnt;
    bus.request = 1'b1;
    wait_valid(1'b1, cyc);
    chk("c1_latency", 32'(cyc), 32'd4);
    chk("c1_strobes", 32'(strobe_cnt - s0), 32'd1);
    chk("c1_strobe_addr", 32'(strobe_addr), 32'd0);
    chk("c1_card", 32'(bus.card), 32'd1);
    chk("c1_points", 32'(bus.points), 32'd1);
    chk("c1_bad", 32'(bus.bad_card), 32'd0);
    tick();
    chk("c1_valid_one_cycle", 32'(bus.card_valid), 32'd0);
    chk("c1_cards_left", 32'(bus.cards_left), 32'd51);
    chk("c1_nextA", 32'(bus.nextA), 32'd1);

    // Request held high: one card every 5 cycles
    bus.request = 1'b1;
    wait_valid(1'b0, cyc);
    chk("held1_latency", 32'(cyc), 32'd4);
    chk("held1_strobe_addr", 32'(strobe_addr), 32'd1);
    chk("held1_card", 32'(bus.card), 32'd12);
    chk("held1_points", 32'(bus.points), 32'd10);
    wait_valid(1'b0, cyc);
    bus.request = 1'b0;
    chk("held2_spacing", 32'(cyc), 32'd5);
    chk("held2_strobe_addr", 32'(strobe_addr), 32'd2);
    chk("held2_card", 32'(bus.card), 32'd10);
    chk("held2_points", 32'(bus.points), 32'd10);
    tick();
    chk("held_cards_left", 32'(bus.cards_left), 32'd49);

    // Table of point-mapping vectors at addresses 3..8
    for (int i = 0; i < 6; i++) begin
      bus.request = 1'b1;
      wait_valid(1'b1, cyc);
      chk("tbl_latency", 32'(cyc), 32'd4);
      chk("tbl_strobe_addr", 32'(strobe_addr), 32'(3 + i));
      chk("tbl_card", 32'(bus.card), 32'(vecs[i].code));
      chk("tbl_points", 32'(bus.points), 32'(vecs[i].exp_points));
      chk("tbl_bad", 32'(bus.bad_card), 32'(vecs[i].exp_bad));
      tick();
      chk("tbl_cards_left", 32'(bus.cards_left), 32'(48 - i));
      if (i == 1) chk("tbl_ptr_after_bad", 32'(bus.nextA), 32'd5);
    end

    // Enable dropped during STROBE of the 10th card
    bus.request = 1'b1;
    tick();
    bus.request = 1'b0;
    tick();
    chk("abort_in_strobe", 32'(bus.memClock), 32'd1);
    chk("abort_nextA_before", 32'(bus.nextA), 32'd9);
    bus.enable = 1'b0;
    vseen = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (bus.card_valid === 1'b1) vseen = vseen + 1;
    end
    chk("abort_no_valid", 32'(vseen), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_cards_left", 32'(bus.cards_left), 32'd52);
    chk("abort_nextA", 32'(bus.nextA), 32'd0);
    chk("abort_card_holds", 32'(bus.card), 32'd5);
    bus.enable = 1'b1;
    tick();
    bus.request = 1'b1;
    wait_valid(1'b1, cyc);
    chk("reen_strobe_addr", 32'(strobe_addr), 32'd0);
    chk("reen_card", 32'(bus.card), 32'd1);
    tick();
    chk("reen_cards_left", 32'(bus.cards_left), 32'd51);

    // Exhaust the deck
    for (int k = 0; k < 51; k++) begin
      bus.request = 1'b1;
      wait_valid(1'b1, cyc);
      tick();
      chk("exh_cards_left", 32'(bus.cards_left), 32'(50 - k));
    end
    chk("exh_last_strobe_addr", 32'(strobe_addr), 32'd51);
    chk("exh_last_card", 32'(bus.card), 32'd13);
    tick();
    chk("exh_empty", 32'(bus.empty), 32'd1);
    chk("exh_busy", 32'(bus.busy), 32'd0);
    s0    = strobe_cnt;
    vseen = 0;
    bus.request = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (bus.card_valid === 1'b1) vseen = vseen + 1;
    end
    bus.request = 1'b0;
    chk("exh_53_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("exh_53_no_valid", 32'(vseen), 32'd0);
    chk("exh_still_empty", 32'(bus.empty), 32'd1);
    chk("wren_never", 32'(strobe_wren), 32'd0);

    // Asynchronous reset in the middle of CAPTURE
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    tick();
    bus.request = 1'b1;
    tick();
    bus.request = 1'b0;
    tick();
    tick();
    chk("ares_in_capture", 32'(bus.busy), 32'd1);
    #3;
    resetn = 1'b0;
    #1;
    chk("ares_card", 32'(bus.card), 32'd0);
    chk("ares_busy", 32'(bus.busy), 32'd0);
    chk("ares_memclock", 32'(bus.memClock), 32'd0);
    chk("ares_cards_left", 32'(bus.cards_left), 32'd52);
    chk("ares_points", 32'(bus.points), 32'd0);
    resetn = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
